// File: rtl/seg_scan_pkg.sv
// Shared types and sizing for the 7-segment scan controller.
// Digit count is fixed here so the index helper and the top agree on widths.
package seg_scan_pkg;

   localparam int NUM_DIGITS  = 6;
   localparam int DIGIT_SEL_W = $clog2(NUM_DIGITS);
   localparam int SEG_W       = 8;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      BLANK,
      SHOW
   } scan_state_e;

   // One-hot decode of a digit index; indices past NUM_DIGITS decode to all zero.
   function automatic logic [NUM_DIGITS-1:0] sel_onehot(input logic [DIGIT_SEL_W-1:0] sel);
      logic [NUM_DIGITS-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         oh[i] = (sel == DIGIT_SEL_W'(i));
      end
      return oh;
   endfunction

endpackage

// File: rtl/seg_scan_next_idx.sv
// Combinational search for the next enabled digit index, with wrap flag.
// inclusive=1 accepts cur itself; otherwise the search starts just after cur.
module seg_scan_next_idx
   import seg_scan_pkg::*;
(
   input  logic [NUM_DIGITS-1:0]  mask,
   input  logic [DIGIT_SEL_W-1:0] cur,
   input  logic                   inclusive,
   output logic [DIGIT_SEL_W-1:0] nxt,
   output logic                   wrap,
   output logic                   valid
);

   logic                   found_fwd;
   logic [DIGIT_SEL_W-1:0] idx_fwd;
   logic [DIGIT_SEL_W-1:0] idx_low;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      found_fwd = 1'b0;
      idx_fwd   = '0;
      idx_low   = '0;
      // Scan high to low so the last hit is the lowest qualifying index.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx_low = DIGIT_SEL_W'(i);
            if ((i > int'(cur)) || (inclusive && (i == int'(cur)))) begin
               found_fwd = 1'b1;
               idx_fwd   = DIGIT_SEL_W'(i);
            end
         end
      end
   end

   assign nxt   = found_fwd ? idx_fwd : idx_low;
   assign wrap  = ~found_fwd;
   assign valid = |mask;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 6-digit 7-segment scan controller: select, blank, then show
// each enabled digit for its dwell, with registered segment and digit drive.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DWELL_W      = 16,
   parameter int BLANK_CYCLES = 2,
   parameter bit DIGIT_ACT_LO = 1'b0
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   ena,
   input  logic                   scan_en,
   input  logic [DWELL_W-1:0]     dwell,
   input  logic [NUM_DIGITS-1:0]  digit_mask,
   input  logic [SEG_W-1:0]       seg_in,
   output logic [DIGIT_SEL_W-1:0] digit_sel,
   output logic [SEG_W-1:0]       seg_out,
   output logic [NUM_DIGITS-1:0]  digit_en,
   output logic                   frame_tick,
   output logic                   busy
);

   localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{DIGIT_ACT_LO}};
   localparam int BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   scan_state_e            state;
   logic [DIGIT_SEL_W-1:0] ptr;
   logic [DWELL_W-1:0]     dwell_cnt;
   logic [BLANK_W-1:0]     blank_cnt;

   logic [DIGIT_SEL_W-1:0] nx_idx;
   logic                   nx_wrap;
   logic                   nx_valid;
   logic [DWELL_W-1:0]     dwell_load;
   logic [NUM_DIGITS-1:0]  show_en;

   // IDLE resumes at ptr (inclusive); SHOW advances past the digit on display.
   seg_scan_next_idx u_next_idx (
      .mask      (digit_mask),
      .cur       ((state == IDLE) ? ptr : digit_sel),
      .inclusive (state == IDLE),
      .nxt       (nx_idx),
      .wrap      (nx_wrap),
      .valid     (nx_valid)
   );

   // A dwell of zero still shows the digit for one cycle.
   assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign show_en    = sel_onehot(digit_sel) ^ EN_OFF;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= IDLE;
         ptr        <= '0;
         digit_sel  <= '0;
         seg_out    <= '0;
         digit_en   <= EN_OFF;
         frame_tick <= 1'b0;
         busy       <= 1'b0;
         dwell_cnt  <= '0;
         blank_cnt  <= '0;
      end else if (ena) begin
         // NOTE: sequential state uses non-blocking assignments so every branch
         // reads the pre-edge values of state, counters and pointers.
         frame_tick <= 1'b0;
         if (!scan_en) begin
            state    <= IDLE;
            digit_en <= EN_OFF;
            seg_out  <= '0;
            busy     <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (nx_valid) begin
                     state     <= SELECT;
                     digit_sel <= nx_idx;
                     busy      <= 1'b1;
                  end
               end

               SELECT: begin
                  if (BLANK_CYCLES == 0) begin
                     state     <= SHOW;
                     seg_out   <= seg_in;
                     dwell_cnt <= dwell_load;
                     digit_en  <= show_en;
                  end else begin
                     state     <= BLANK;
                     blank_cnt <= BLANK_W'(BLANK_LOAD);
                  end
               end

               BLANK: begin
                  if (blank_cnt == '0) begin
                     state     <= SHOW;
                     seg_out   <= seg_in;
                     dwell_cnt <= dwell_load;
                     digit_en  <= show_en;
                  end else begin
                     blank_cnt <= blank_cnt - BLANK_W'(1);
                  end
               end

               SHOW: begin
                  // The dwell always completes; the mask is consulted only on the last cycle.
                  if (dwell_cnt == '0) begin
                     digit_en <= EN_OFF;
                     if (nx_valid) begin
                        state      <= SELECT;
                        ptr        <= nx_idx;
                        digit_sel  <= nx_idx;
                        frame_tick <= nx_wrap;
                     end else begin
                        state   <= IDLE;
                        seg_out <= '0;
                        busy    <= 1'b0;
                     end
                  end else begin
                     dwell_cnt <= dwell_cnt - DWELL_W'(1);
                  end
               end

               default: begin
                  state    <= IDLE;
                  digit_en <= EN_OFF;
                  seg_out  <= '0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus a randomized
// run, compared every cycle against a period-position reference model.
module tb_seg_scan_ctrl;
   import seg_scan_pkg::*;

   localparam int B  = 2;
   localparam int DW = 16;

   logic                   clk = 1'b0;
   logic                   rstb;
   logic                   ena;
   logic                   scan_en;
   logic [DW-1:0]          dwell;
   logic [NUM_DIGITS-1:0]  digit_mask;
   logic [SEG_W-1:0]       seg_in;
   logic [DIGIT_SEL_W-1:0] digit_sel;
   logic [SEG_W-1:0]       seg_out;
   logic [NUM_DIGITS-1:0]  digit_en;
   logic                   frame_tick;
   logic                   busy;

   logic [SEG_W-1:0] pat [NUM_DIGITS];

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: position m_t inside the current digit period
   // (0 = select, 1..B = blank, B+1..B+m_len = show).
   bit               m_busy;
   bit               m_tick;
   int               m_digit;
   int               m_ptr;
   int               m_t;
   int               m_len;
   logic [SEG_W-1:0] m_seg;

   seg_scan_ctrl #(
      .DWELL_W      (DW),
      .BLANK_CYCLES (B),
      .DIGIT_ACT_LO (1'b0)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .ena        (ena),
      .scan_en    (scan_en),
      .dwell      (dwell),
      .digit_mask (digit_mask),
      .seg_in     (seg_in),
      .digit_sel  (digit_sel),
      .seg_out    (seg_out),
      .digit_en   (digit_en),
      .frame_tick (frame_tick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign seg_in = (int'(digit_sel) < NUM_DIGITS) ? pat[digit_sel] : 8'h00;

   function automatic int first_from(input logic [NUM_DIGITS-1:0] m, input int start);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         int i;
         i = (start + k) % NUM_DIGITS;
         if (m[i]) return i;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_tick  = 1'b0;
      m_digit = 0;
      m_ptr   = 0;
      m_t     = 0;
      m_len   = 1;
      m_seg   = '0;
   endtask

   task automatic model_step();
      int nd;
      if (!ena) return;
      m_tick = 1'b0;
      if (!scan_en) begin
         m_busy = 1'b0;
         m_seg  = '0;
      end else if (!m_busy) begin
         if (digit_mask != '0) begin
            m_busy  = 1'b1;
            m_digit = first_from(digit_mask, m_ptr);
            m_t     = 0;
         end
      end else begin
         m_t++;
         if (m_t == B + 1) begin
            m_len = (dwell == '0) ? 1 : int'(dwell);
            m_seg = pat[m_digit];
         end else if (m_t == B + 1 + m_len) begin
            nd = first_from(digit_mask, m_digit + 1);
            if (nd < 0) begin
               m_busy = 1'b0;
               m_seg  = '0;
            end else begin
               m_tick  = (nd <= m_digit);
               m_ptr   = nd;
               m_digit = nd;
               m_t     = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] exp_en;
      exp_en = (m_busy && (m_t >= B + 1)) ? (32'(1) << m_digit) : 32'(0);
      check("sel", 32'(digit_sel), 32'(m_digit));
      check("seg", 32'(seg_out), 32'(m_seg));
      check("en", 32'(digit_en), exp_en);
      check("tick", 32'(frame_tick), 32'(m_tick));
      check("busy", 32'(busy), 32'(m_busy));
      check("onehot", 32'($countones(digit_en) <= 1), 32'(1));
   endtask

   // One clock: model follows the edge, DUT outputs are checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (rstb) model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_show(input int budget, input string tag);
      int c;
      c = 0;
      while (digit_en == '0 && c < budget) begin
         tick();
         c++;
      end
      check(tag, 32'(c < budget), 32'(1));
   endtask

   task automatic measure_show(input int budget, input string tag,
                               output logic [NUM_DIGITS-1:0] en, output int len);
      wait_show(budget, tag);
      en  = digit_en;
      len = 1;
      while (len < budget) begin
         tick();
         if (digit_en != en) break;
         len++;
      end
   endtask

   task automatic wait_frame(input int budget, input string tag, output int c);
      c = 0;
      do begin
         tick();
         c++;
      end while (!frame_tick && c < budget);
      check(tag, 32'(frame_tick), 32'(1));
   endtask

   initial begin
      logic [NUM_DIGITS-1:0] en_a, en_b;
      int len_a, len_b, c, ticks, exp_idx;

      for (int i = 0; i < NUM_DIGITS; i++) pat[i] = SEG_W'($urandom);
      rstb       = 1'b0;
      ena        = 1'b1;
      scan_en    = 1'b0;
      dwell      = DW'(3);
      digit_mask = '0;
      model_reset();
      repeat (2) tick();
      rstb = 1'b1;

      // Two digits, dwell 3: alternate shows of 3 cycles, frame every 12 cycles.
      digit_mask = 6'b000011;
      scan_en    = 1'b1;
      wait_frame(40, "t1_first_frame", c);
      wait_frame(40, "t1_second_frame", c);
      check("t1_frame_period", 32'(c), 32'(12));
      measure_show(40, "t1_show_a", en_a, len_a);
      measure_show(40, "t1_show_b", en_b, len_b);
      check("t1_len_a", 32'(len_a), 32'(3));
      check("t1_len_b", 32'(len_b), 32'(3));
      check("t1_alternate", 32'(en_a ^ en_b), 32'(6'b000011));

      // Sparse mask: digits 3 and 5 alternate, segments follow the mux model.
      digit_mask = 6'b101000;
      repeat (20) tick();
      measure_show(40, "t2_show_a", en_a, len_a);
      measure_show(40, "t2_show_b", en_b, len_b);
      check("t2_pair", 32'(en_a ^ en_b), 32'(6'b101000));

      // Dwell 0 behaves as 1; maximum dwell on the first shown digit.
      dwell = '0;
      repeat (20) tick();
      measure_show(40, "t3_show_d0", en_a, len_a);
      check("t3_len_d0", 32'(len_a), 32'(1));
      dwell = 16'hFFFF;
      measure_show(70000, "t3_show_max", en_a, len_a);
      check("t3_len_max", 32'(len_a), 32'(65535));

      // scan_en dropped mid-show: immediate idle, then resume at the held pointer.
      dwell      = DW'(4);
      digit_mask = 6'b010110;
      repeat (12) tick();
      wait_show(40, "t4_show");
      tick();
      scan_en = 1'b0;
      exp_idx = first_from(digit_mask, m_ptr);
      tick();
      check("t4_busy", 32'(busy), 32'(0));
      check("t4_en", 32'(digit_en), 32'(0));
      check("t4_seg", 32'(seg_out), 32'(0));
      repeat (3) tick();
      scan_en = 1'b1;
      measure_show(40, "t4_resume_show", en_a, len_a);
      check("t4_resume", 32'(en_a), 32'(1) << exp_idx);
      check("t4_len", 32'(len_a), 32'(4));

      // Mask cleared mid-show: dwell completes, then idle with no frame tick.
      wait_show(40, "t5_show");
      digit_mask = '0;
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (frame_tick) ticks++;
      end
      check("t5_no_tick", 32'(ticks), 32'(0));
      check("t5_idle", 32'(busy), 32'(0));

      // Async reset during blank; scanning restarts at digit 0.
      digit_mask = 6'b000110;
      dwell      = DW'(3);
      c = 0;
      while (!(m_busy && m_digit == 2 && m_t == 1) && c < 100) begin
         tick();
         c++;
      end
      check("t6_reach_blank", 32'(c < 100), 32'(1));
      #2 rstb = 1'b0;
      #1;
      check("t6_rst_busy", 32'(busy), 32'(0));
      check("t6_rst_en", 32'(digit_en), 32'(0));
      check("t6_rst_seg", 32'(seg_out), 32'(0));
      check("t6_rst_sel", 32'(digit_sel), 32'(0));
      check("t6_rst_tick", 32'(frame_tick), 32'(0));
      model_reset();
      repeat (2) tick();
      digit_mask = 6'b000111;
      rstb       = 1'b1;
      measure_show(40, "t6_restart_show", en_a, len_a);
      check("t6_restart_digit", 32'(en_a), 32'(1));

      // Randomized traffic on mask, dwell, scan_en and ena.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) digit_mask = NUM_DIGITS'($urandom);
         if ($urandom_range(0, 29) == 0) dwell = DW'($urandom_range(0, 5));
         if ($urandom_range(0, 39) == 0) scan_en = ($urandom_range(0, 7) != 0);
         ena = ($urandom_range(0, 9) != 0);
         tick();
      end
      ena = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
